bp_me_nonsynth_mock_lce_tag_mem: RTL and testbench

Non-synthesizable tag/state array for the mock LCE in the ME testbench. Holds `sets_p × assoc_p` packed `{tag, state}` entries and returns one full set per read, registered, to feed the mock LCE tag-lookup stage directly. Accepts single-way writes from the mock LCE's command handling and tracks a per-set round-robin victim way. After reset it invalidates the whole array with an internal clear sequence before accepting traffic.

---
 rtl/bp_me_nonsynth_mock_lce_tag_mem_if.sv | 48 ++++
 rtl/bp_me_nonsynth_mock_lce_tag_mem.sv | 145 ++++++++++++++
 tb/tb_bp_me_nonsynth_mock_lce_tag_mem.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_me_nonsynth_mock_lce_tag_mem_if.sv
// Port bundle for the mock LCE tag/state array: set read request, registered
// set response with victim pointer, single-way write, and the ready flag.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

interface bp_me_nonsynth_mock_lce_tag_mem_if #(
    parameter int sets_p       = 64,
    parameter int assoc_p      = 8,
    parameter int ptag_width_p = 28
);
    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    localparam int lg_sets_lp     = `BSG_SAFE_CLOG2(sets_p);
    localparam int lg_assoc_lp    = `BSG_SAFE_CLOG2(assoc_p);
    localparam int state_width_lp = $bits(bp_coh_states_e);
    localparam int tag_s_width_lp = state_width_lp + ptag_width_p;

    logic                                    ready_o;
    logic                                    rd_v_i;
    logic [lg_sets_lp-1:0]                   rd_set_i;
    logic [assoc_p-1:0][tag_s_width_lp-1:0]  tag_set_o;
    logic                                    tag_set_v_o;
    logic [lg_assoc_lp-1:0]                  victim_way_o;
    logic                                    wr_v_i;
    logic [lg_sets_lp-1:0]                   wr_set_i;
    logic [lg_assoc_lp-1:0]                  wr_way_i;
    logic                                    wr_op_i;
    logic [ptag_width_p-1:0]                 wr_tag_i;
    logic [state_width_lp-1:0]               wr_state_i;

    modport master (
        input  ready_o, tag_set_o, tag_set_v_o, victim_way_o,
        output rd_v_i, rd_set_i, wr_v_i, wr_set_i, wr_way_i, wr_op_i, wr_tag_i, wr_state_i
    );

    modport slave (
        output ready_o, tag_set_o, tag_set_v_o, victim_way_o,
        input  rd_v_i, rd_set_i, wr_v_i, wr_set_i, wr_way_i, wr_op_i, wr_tag_i, wr_state_i
    );
endinterface

// File: rtl/bp_me_nonsynth_mock_lce_tag_mem.sv
// Mock LCE tag/state array with per-set round-robin victim pointers and a
// post-reset clear sweep. Define BP_ME_MOCK_LCE_TAG_MEM_BYPASS_EN to forward same-set writes to reads.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bp_me_nonsynth_mock_lce_tag_mem #(
    parameter int sets_p       = 64,
    parameter int assoc_p      = 8,
    parameter int ptag_width_p = 28
) (
    input logic clk_i,
    input logic reset_i,
    bp_me_nonsynth_mock_lce_tag_mem_if.slave tag_if
);
    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    localparam int lg_sets_lp     = `BSG_SAFE_CLOG2(sets_p);
    localparam int lg_assoc_lp    = `BSG_SAFE_CLOG2(assoc_p);
    localparam int state_width_lp = $bits(bp_coh_states_e);
    localparam int tag_s_width_lp = state_width_lp + ptag_width_p;

    localparam logic [tag_s_width_lp-1:0] clear_entry_lp = {ptag_width_p'(0), e_COH_I};

    typedef enum logic [1:0] {e_reset, e_clear, e_ready} fsm_e;

    fsm_e                                   fsm_reg, fsm_next;
    logic [lg_sets_lp-1:0]                  clear_cnt_reg, clear_cnt_next;
    logic [assoc_p-1:0][tag_s_width_lp-1:0] tag_mem [sets_p];
    logic [lg_assoc_lp-1:0]                 victim_ptr [sets_p];

    logic                                   clear_en, wr_en, rd_en;
    logic [tag_s_width_lp-1:0]              wr_entry;
    logic [assoc_p-1:0][tag_s_width_lp-1:0] rd_set_data;
    logic [lg_assoc_lp-1:0]                 rd_victim;

    logic [assoc_p-1:0][tag_s_width_lp-1:0] tag_set_reg;
    logic                                   tag_set_v_reg;
    logic [lg_assoc_lp-1:0]                 victim_way_reg;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_reg       <= e_reset;
            clear_cnt_reg <= '0;
        end else begin
            fsm_reg       <= fsm_next;
            clear_cnt_reg <= clear_cnt_next;
        end
    end

    always_comb begin
        fsm_next       = fsm_reg;
        clear_cnt_next = clear_cnt_reg;
        case (fsm_reg)
            e_reset: begin
                fsm_next       = e_clear;
                clear_cnt_next = '0;
            end
            e_clear: begin
                clear_cnt_next = clear_cnt_reg + lg_sets_lp'(1);
                if (clear_cnt_reg == lg_sets_lp'(sets_p - 1)) begin
                    fsm_next = e_ready;
                end
            end
            default: fsm_next = e_ready;
        endcase
    end

    assign clear_en = (fsm_reg == e_clear);
    assign wr_en    = (fsm_reg == e_ready) && tag_if.wr_v_i;
    assign rd_en    = (fsm_reg == e_ready) && tag_if.rd_v_i;
    assign wr_entry = {tag_if.wr_tag_i, tag_if.wr_state_i};

    // Array needs no reset of its own: the clear sweep owns initialisation.
    always_ff @(posedge clk_i) begin
        if (clear_en) begin
            tag_mem[clear_cnt_reg] <= {assoc_p{clear_entry_lp}};
        end else if (wr_en) begin
            if (tag_if.wr_op_i) begin
                tag_mem[tag_if.wr_set_i][tag_if.wr_way_i] <= wr_entry;
            end else begin
                tag_mem[tag_if.wr_set_i][tag_if.wr_way_i][state_width_lp-1:0] <= tag_if.wr_state_i;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < sets_p; gi++) begin : g_victim
            logic [lg_assoc_lp-1:0] victim_reg;

            always_ff @(posedge clk_i) begin
                if (clear_en && (clear_cnt_reg == lg_sets_lp'(gi))) begin
                    victim_reg <= '0;
                end else if (wr_en && tag_if.wr_op_i && (tag_if.wr_set_i == lg_sets_lp'(gi))) begin
                    victim_reg <= victim_reg + lg_assoc_lp'(1);
                end
            end

            assign victim_ptr[gi] = victim_reg;
        end
    endgenerate

    always_comb begin
        rd_set_data = tag_mem[tag_if.rd_set_i];
        rd_victim   = victim_ptr[tag_if.rd_set_i];
`ifdef BP_ME_MOCK_LCE_TAG_MEM_BYPASS_EN
        if (wr_en && (tag_if.wr_set_i == tag_if.rd_set_i)) begin
            if (tag_if.wr_op_i) begin
                rd_set_data[tag_if.wr_way_i] = wr_entry;
                rd_victim                    = rd_victim + lg_assoc_lp'(1);
            end else begin
                rd_set_data[tag_if.wr_way_i][state_width_lp-1:0] = tag_if.wr_state_i;
            end
        end
`endif
    end

    // Outputs hold the last read when idle; only the valid flag drops.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tag_set_reg    <= '0;
            tag_set_v_reg  <= 1'b0;
            victim_way_reg <= '0;
        end else begin
            tag_set_v_reg <= rd_en;
            if (rd_en) begin
                tag_set_reg    <= rd_set_data;
                victim_way_reg <= rd_victim;
            end
        end
    end

    assign tag_if.ready_o      = (fsm_reg == e_ready);
    assign tag_if.tag_set_o    = tag_set_reg;
    assign tag_if.tag_set_v_o  = tag_set_v_reg;
    assign tag_if.victim_way_o = victim_way_reg;
endmodule

// File: tb/tb_bp_me_nonsynth_mock_lce_tag_mem.sv
// Directed bench for the mock LCE tag memory: clear timing, write/read,
// state-only writes, victim wrap, same-set collision and mid-clear reset.
`timescale 1ns/1ps

module tb_bp_me_nonsynth_mock_lce_tag_mem;
    localparam int sets_p         = 64;
    localparam int assoc_p        = 8;
    localparam int ptag_width_p   = 28;
    localparam int tag_s_width_lp = ptag_width_p + 3;

    localparam logic [2:0] coh_s = 3'b001;
    localparam logic [2:0] coh_e = 3'b010;
    localparam logic [2:0] coh_m = 3'b110;

    typedef logic [assoc_p-1:0][tag_s_width_lp-1:0] set_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    bp_me_nonsynth_mock_lce_tag_mem_if #(
        .sets_p(sets_p), .assoc_p(assoc_p), .ptag_width_p(ptag_width_p)
    ) tag_if ();

    bp_me_nonsynth_mock_lce_tag_mem #(
        .sets_p(sets_p), .assoc_p(assoc_p), .ptag_width_p(ptag_width_p)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .tag_if (tag_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_set(input string name, input set_t obs, input set_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tag_if.rd_v_i     = 1'b0;
        tag_if.rd_set_i   = '0;
        tag_if.wr_v_i     = 1'b0;
        tag_if.wr_set_i   = '0;
        tag_if.wr_way_i   = '0;
        tag_if.wr_op_i    = 1'b0;
        tag_if.wr_tag_i   = '0;
        tag_if.wr_state_i = '0;
    endtask

    task automatic drive_rd(input logic [5:0] set);
        tag_if.rd_v_i   = 1'b1;
        tag_if.rd_set_i = set;
    endtask

    task automatic drive_wr(input logic [5:0] set, input logic [2:0] way, input logic op,
                            input logic [27:0] tag, input logic [2:0] st);
        tag_if.wr_v_i     = 1'b1;
        tag_if.wr_set_i   = set;
        tag_if.wr_way_i   = way;
        tag_if.wr_op_i    = op;
        tag_if.wr_tag_i   = tag;
        tag_if.wr_state_i = st;
    endtask

    function automatic set_t one_way(input int way, input logic [27:0] tag, input logic [2:0] st);
        set_t s;
        s      = '0;
        s[way] = {tag, st};
        return s;
    endfunction

    task automatic wait_ready(input string name);
        int rise;
        rise = 0;
        for (int e = 1; e <= 100 && rise == 0; e++) begin
            step();
            if (tag_if.ready_o === 1'b1) rise = e;
        end
        check_val(name, 32'(rise), 32'd65);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_t exp_set;

        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_ready", 32'(tag_if.ready_o), 32'd0);
        check_val("reset_valid", 32'(tag_if.tag_set_v_o), 32'd0);
        check_set("reset_tag_set", tag_if.tag_set_o, '0);
        check_val("reset_victim", 32'(tag_if.victim_way_o), 32'd0);

        // Clear sweep: ready must first appear on edge 65 after release
        @(negedge clk);
        rst = 1'b0;
        wait_ready("clear_ready_edge");

        for (int s = 0; s < sets_p; s++) begin
            drive_rd(6'(s));
            step();
            check_set("clear_set_contents", tag_if.tag_set_o, '0);
            check_val("clear_set_victim", 32'(tag_if.victim_way_o), 32'd0);
            check_val("clear_set_valid", 32'(tag_if.tag_set_v_o), 32'd1);
        end
        idle();
        step();
        check_val("idle_valid_low", 32'(tag_if.tag_set_v_o), 32'd0);

        // Full write then read
        drive_wr(6'd5, 3'd3, 1'b1, 28'h1A2B, coh_m);
        step();
        idle();
        drive_rd(6'd5);
        step();
        idle();
        check_set("wr_rd_set5", tag_if.tag_set_o, one_way(3, 28'h1A2B, coh_m));
        check_val("wr_rd_victim", 32'(tag_if.victim_way_o), 32'd1);
        check_val("wr_rd_valid", 32'(tag_if.tag_set_v_o), 32'd1);
        step();
        check_val("wr_rd_valid_one_cycle", 32'(tag_if.tag_set_v_o), 32'd0);
        check_set("wr_rd_hold", tag_if.tag_set_o, one_way(3, 28'h1A2B, coh_m));

        // State-only write ignores the supplied tag and leaves the victim alone
        drive_wr(6'd5, 3'd3, 1'b0, 28'h3C3C, coh_s);
        step();
        idle();
        drive_rd(6'd5);
        step();
        idle();
        check_set("state_only_set5", tag_if.tag_set_o, one_way(3, 28'h1A2B, coh_s));
        check_val("state_only_victim", 32'(tag_if.victim_way_o), 32'd1);

        // Victim wrap on set 9
        exp_set = '0;
        for (int i = 0; i < assoc_p; i++) begin
            drive_wr(6'd9, 3'(i), 1'b1, 28'(32'h100 + i), coh_e);
            exp_set[i] = {28'(32'h100 + i), coh_e};
            step();
        end
        idle();
        drive_rd(6'd9);
        step();
        idle();
        check_set("wrap_set9", tag_if.tag_set_o, exp_set);
        check_val("wrap_victim_zero", 32'(tag_if.victim_way_o), 32'd0);
        drive_wr(6'd9, 3'd0, 1'b1, 28'h200, coh_m);
        exp_set[0] = {28'h200, coh_m};
        step();
        idle();
        drive_rd(6'd9);
        step();
        idle();
        check_set("wrap_set9_ninth", tag_if.tag_set_o, exp_set);
        check_val("wrap_victim_one", 32'(tag_if.victim_way_o), 32'd1);

        // Same-set collision on set 2
        drive_wr(6'd2, 3'd0, 1'b1, 28'h77, coh_m);
        drive_rd(6'd2);
        step();
        idle();
`ifdef BP_ME_MOCK_LCE_TAG_MEM_BYPASS_EN
        check_set("collide_set2", tag_if.tag_set_o, one_way(0, 28'h77, coh_m));
        check_val("collide_victim", 32'(tag_if.victim_way_o), 32'd1);
`else
        check_set("collide_set2", tag_if.tag_set_o, '0);
        check_val("collide_victim", 32'(tag_if.victim_way_o), 32'd0);
`endif
        drive_rd(6'd2);
        step();
        idle();
        check_set("collide_reread", tag_if.tag_set_o, one_way(0, 28'h77, coh_m));
        check_val("collide_reread_victim", 32'(tag_if.victim_way_o), 32'd1);

        // Read and write to different sets in the same cycle
        drive_wr(6'd6, 3'd1, 1'b1, 28'h55, coh_m);
        drive_rd(6'd5);
        step();
        idle();
        check_set("indep_set5", tag_if.tag_set_o, one_way(3, 28'h1A2B, coh_s));
        drive_rd(6'd6);
        step();
        idle();
        check_set("indep_set6", tag_if.tag_set_o, one_way(1, 28'h55, coh_m));
        check_val("indep_victim6", 32'(tag_if.victim_way_o), 32'd1);

        // Reset while outputs hold live data
        drive_rd(6'd5);
        step();
        #2;
        rst = 1'b1;
        #1;
        check_val("midop_reset_ready", 32'(tag_if.ready_o), 32'd0);
        check_val("midop_reset_valid", 32'(tag_if.tag_set_v_o), 32'd0);
        check_set("midop_reset_tag_set", tag_if.tag_set_o, '0);
        check_val("midop_reset_victim", 32'(tag_if.victim_way_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Traffic during clear is ignored; reset again at clear cycle 10
        drive_wr(6'd5, 3'd2, 1'b1, 28'hAAA, coh_m);
        for (int e = 1; e <= 11; e++) begin
            step();
            check_val("clear_rd_ignored", 32'(tag_if.tag_set_v_o), 32'd0);
        end
        check_val("clear_not_ready", 32'(tag_if.ready_o), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_val("midclear_reset_valid", 32'(tag_if.tag_set_v_o), 32'd0);
        check_set("midclear_reset_tag_set", tag_if.tag_set_o, '0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        wait_ready("reclear_ready_edge");

        drive_rd(6'd5);
        step();
        check_set("reclear_set5", tag_if.tag_set_o, '0);
        check_val("reclear_victim5", 32'(tag_if.victim_way_o), 32'd0);
        drive_rd(6'd9);
        step();
        idle();
        check_set("reclear_set9", tag_if.tag_set_o, '0);
        check_val("reclear_victim9", 32'(tag_if.victim_way_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
